// File: rtl/bitstream_word_loader.sv
// bitstream_word_loader
// Collects an incoming byte stream MSB-first into 32-bit configuration words
// and hands each word to the fabric with a fixed setup / strobe / gap sequence.
// A load is started with a byte count. It ends in DONE after the last word is
// written, or returns to IDLE on abort or when the start is rejected.
module bitstream_word_loader #(
   parameter int MAX_BYTES = 21140,
   parameter int SETUP_CYC = 2,
   parameter int GAP_CYC   = 2
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic        start,
   input  logic [15:0] total_bytes,
   input  logic        abort,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [31:0] SelfWriteData,
   output logic        SelfWriteStrobe,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_SETUP   = 3'd2,
      S_STROBE  = 3'd3,
      S_GAP     = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // Last timer value of each timed phase. A zero-length phase is skipped.
   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
   localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
   localparam logic [16:0] MAX_LEN    = 17'(MAX_BYTES);
   localparam bit          SETUP_NONE = (SETUP_CYC == 0);
   localparam bit          GAP_NONE   = (GAP_CYC == 0);

   state_t      state_q;
   logic [15:0] words_total_q;   // words to write in this load (total_bytes / 4)
   logic [15:0] byte_cnt_q;      // bytes accepted in this load
   logic [15:0] word_cnt_q;      // words already handed to the fabric
   logic [15:0] timer_q;         // cycle counter for SETUP and GAP
   logic [31:0] word_q;          // word under assembly
   logic [31:0] data_q;          // word presented on SelfWriteData
   logic        ready_q;
   logic        strobe_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;

   logic [31:0] word_d;
   logic [15:0] byte_cnt_d;
   logic        accept;
   logic        word_full;
   logic        len_ok;
   logic        last_word;

   // Byte handshake, start-length check and next assembly word
   always_comb begin
      accept     = byte_valid & ready_q;
      word_d     = {word_q[23:0], byte_data};
      byte_cnt_d = byte_cnt_q + 16'd1;
      word_full  = (byte_cnt_q[1:0] == 2'b11);
      len_ok     = (total_bytes != 16'd0) && (total_bytes[1:0] == 2'b00) &&
                   ({1'b0, total_bytes} <= MAX_LEN);
      last_word  = (word_cnt_q == words_total_q);
   end

   // Control FSM with registered outputs; abort overrides every other event
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         words_total_q <= 16'd0;
         byte_cnt_q    <= 16'd0;
         word_cnt_q    <= 16'd0;
         timer_q       <= 16'd0;
         word_q        <= 32'd0;
         data_q        <= 32'd0;
         ready_q       <= 1'b0;
         strobe_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else if (abort) begin
         // Abort only acts while a load is running; SelfWriteData is kept
         if (busy_q) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 16'd0;
            timer_q    <= 16'd0;
            word_q     <= 32'd0;
            ready_q    <= 1'b0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
         end
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (len_ok) begin
                     state_q       <= S_COLLECT;
                     words_total_q <= {2'b00, total_bytes[15:2]};
                     byte_cnt_q    <= 16'd0;
                     word_cnt_q    <= 16'd0;
                     timer_q       <= 16'd0;
                     word_q        <= 32'd0;
                     ready_q       <= 1'b1;
                     busy_q        <= 1'b1;
                     done_q        <= 1'b0;
                     err_q         <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (accept) begin
                  word_q     <= word_d;
                  byte_cnt_q <= byte_cnt_d;
                  if (word_full) begin
                     // Word complete: present it now, strobe after the setup time
                     data_q     <= word_d;
                     word_cnt_q <= word_cnt_q + 16'd1;
                     ready_q    <= 1'b0;
                     timer_q    <= 16'd0;
                     if (SETUP_NONE) begin
                        state_q  <= S_STROBE;
                        strobe_q <= 1'b1;
                     end else begin
                        state_q <= S_SETUP;
                     end
                  end
               end
            end
            S_SETUP: begin
               if (timer_q == SETUP_LAST) begin
                  state_q  <= S_STROBE;
                  strobe_q <= 1'b1;
                  timer_q  <= 16'd0;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            S_STROBE: begin
               strobe_q <= 1'b0;
               timer_q  <= 16'd0;
               if (!GAP_NONE) begin
                  state_q <= S_GAP;
               end else if (last_word) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_COLLECT;
                  ready_q <= 1'b1;
               end
            end
            S_GAP: begin
               if (timer_q == GAP_LAST) begin
                  timer_q <= 16'd0;
                  if (last_word) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_COLLECT;
                     ready_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               ready_q  <= 1'b0;
               strobe_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready      = ready_q;
   assign SelfWriteData   = data_q;
   assign SelfWriteStrobe = strobe_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err             = err_q;

endmodule

// File: tb/tb_bitstream_word_loader.sv
// Testbench for bitstream_word_loader: start-length table, directed corner
// sequences and randomized loads checked against a word/timing reference model.
module tb_bitstream_word_loader;

   localparam int SETUP_CYC = 2;
   localparam int GAP_CYC   = 2;

   logic        CLK;
   logic        resetn;
   logic        start;
   logic [15:0] total_bytes;
   logic        abort;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] SelfWriteData;
   logic        SelfWriteStrobe;
   logic        busy;
   logic        done;
   logic        err;

   bitstream_word_loader #(
      .MAX_BYTES(21140),
      .SETUP_CYC(SETUP_CYC),
      .GAP_CYC  (GAP_CYC)
   ) dut (
      .CLK            (CLK),
      .resetn         (resetn),
      .start          (start),
      .total_bytes    (total_bytes),
      .abort          (abort),
      .byte_data      (byte_data),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .SelfWriteData  (SelfWriteData),
      .SelfWriteStrobe(SelfWriteStrobe),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0]  stim_q[$];
   logic [31:0] str_dat_q[$];
   int          str_cyc_q[$];
   int          acc_cyc_q[$];

   // Cycle counter and passive observer of strobes and accepted bytes
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (SelfWriteStrobe) begin
         str_dat_q.push_back(SelfWriteData);
         str_cyc_q.push_back(cyc);
      end
      if (byte_valid && byte_ready) acc_cyc_q.push_back(cyc);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [15:0] len);
      @(posedge CLK); #1;
      start = 1'b1;
      total_bytes = len;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
   endtask

   // Drive stim_q[first..last-1]; mode 0 always valid, 1 alternate, 2 random gaps
   task automatic send_bytes(input int first, input int last, input int mode);
      int idx;
      int n;
      int budget;
      idx = first;
      n = 0;
      budget = 12 * (last - first) + 50;
      while (idx < last && n < budget) begin
         @(posedge CLK); #1;
         byte_data = stim_q[idx];
         case (mode)
            0:       byte_valid = 1'b1;
            1:       byte_valid = (n % 2 == 0);
            default: byte_valid = ($urandom_range(0, 2) != 0);
         endcase
         @(negedge CLK);
         if (byte_valid && byte_ready) idx++;
         n++;
      end
      @(posedge CLK); #1;
      byte_valid = 1'b0;
      if (idx < last) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: sent %0d of %0d bytes", idx - first, last - first);
      end
   endtask

   task automatic wait_done(output int dcyc);
      int n;
      n = 0;
      dcyc = -1;
      while (n < 200 && dcyc < 0) begin
         @(negedge CLK);
         if (done) dcyc = cyc;
         n++;
      end
      if (dcyc < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done not seen, got 0 expected 1");
      end
   endtask

   // Reference model: words are the byte list taken four at a time MSB-first,
   // each strobe lands SETUP_CYC+1 cycles after its 4th byte is accepted and
   // done rises GAP_CYC+1 cycles after the final strobe.
   task automatic verify_load(input string tag, input int sb, input int ab, input int dcyc);
      int n;
      int nw;
      int bad_d;
      int bad_t;
      logic [31:0] exp;
      n = stim_q.size();
      nw = n / 4;
      bad_d = 0;
      bad_t = 0;
      check({tag, "_accepts"}, acc_cyc_q.size() - ab, n);
      check({tag, "_strobes"}, str_dat_q.size() - sb, nw);
      for (int i = 0; i < nw; i++) begin
         exp = {stim_q[4*i], stim_q[4*i+1], stim_q[4*i+2], stim_q[4*i+3]};
         if (sb + i >= str_dat_q.size() || ab + 4*i + 3 >= acc_cyc_q.size()) begin
            bad_d++;
            bad_t++;
         end else begin
            if (str_dat_q[sb+i] !== exp) bad_d++;
            if (str_cyc_q[sb+i] != acc_cyc_q[ab+4*i+3] + SETUP_CYC + 1) bad_t++;
         end
      end
      check({tag, "_bad_words"}, bad_d, 0);
      check({tag, "_bad_strobe_timing"}, bad_t, 0);
      if (acc_cyc_q.size() >= ab + n && n > 0)
         check({tag, "_done_cycle"}, dcyc, acc_cyc_q[ab+n-1] + SETUP_CYC + GAP_CYC + 2);
      else begin
         checks++;
         errors++;
         $display("FAIL %s_done_cycle: got %0d accepts expected %0d", tag, acc_cyc_q.size() - ab, n);
      end
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_ready"}, byte_ready, 1'b0);
   endtask

   typedef struct {
      logic [15:0] len;
      logic        exp_err;
      logic        exp_busy;
   } vec_t;

   vec_t vt[9];

   initial begin
      int sb;
      int ab;
      int dcyc;
      int n;
      int len;

      vt[0] = '{16'd0,     1'b1, 1'b0};
      vt[1] = '{16'd6,     1'b1, 1'b0};
      vt[2] = '{16'd21144, 1'b1, 1'b0};
      vt[3] = '{16'd4,     1'b0, 1'b1};
      vt[4] = '{16'd21141, 1'b1, 1'b0};
      vt[5] = '{16'd3,     1'b1, 1'b0};
      vt[6] = '{16'd21140, 1'b0, 1'b1};
      vt[7] = '{16'd65532, 1'b1, 1'b0};
      vt[8] = '{16'd8,     1'b0, 1'b1};

      start = 1'b0;
      total_bytes = 16'd0;
      abort = 1'b0;
      byte_data = 8'd0;
      byte_valid = 1'b0;
      resetn = 1'b1;

      // Reset values
      #1 resetn = 1'b0;
      #1;
      check("rst_strobe", SelfWriteStrobe, 1'b0);
      check("rst_data", SelfWriteData, 32'd0);
      check("rst_ready", byte_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      repeat (2) @(posedge CLK);
      #1 resetn = 1'b1;

      // Start-length table
      sb = str_dat_q.size();
      for (int i = 0; i < 9; i++) begin
         do_start(vt[i].len);
         check($sformatf("tbl%0d_err", i), err, vt[i].exp_err);
         check($sformatf("tbl%0d_busy", i), busy, vt[i].exp_busy);
         check($sformatf("tbl%0d_ready", i), byte_ready, vt[i].exp_busy);
         check($sformatf("tbl%0d_done", i), done, 1'b0);
         if (vt[i].exp_busy) begin
            pulse_abort();
            check($sformatf("tbl%0d_abort_busy", i), busy, 1'b0);
            check($sformatf("tbl%0d_abort_ready", i), byte_ready, 1'b0);
         end
      end
      repeat (4) @(posedge CLK);
      check("tbl_strobes", str_dat_q.size() - sb, 0);

      // Basic load, then the same stream with alternate-cycle backpressure
      for (int m = 0; m < 2; m++) begin
         stim_q = '{8'h20, 8'ha6, 8'h6c, 8'hfb, 8'h0a, 8'h45, 8'h16, 8'hcf};
         sb = str_dat_q.size();
         ab = acc_cyc_q.size();
         do_start(16'd8);
         send_bytes(0, 8, m);
         wait_done(dcyc);
         verify_load(m == 0 ? "basic" : "bp", sb, ab, dcyc);
         check(m == 0 ? "basic_w0" : "bp_w0",
               (str_dat_q.size() > sb) ? str_dat_q[sb] : 32'd0, 32'h20a66cfb);
         check(m == 0 ? "basic_w1" : "bp_w1",
               (str_dat_q.size() > sb + 1) ? str_dat_q[sb+1] : 32'd0, 32'h0a4516cf);
      end

      // Start pulsed during SETUP is ignored
      sb = str_dat_q.size();
      ab = acc_cyc_q.size();
      do_start(16'd8);
      send_bytes(0, 4, 0);
      start = 1'b1;
      total_bytes = 16'd6;
      @(posedge CLK); #1;
      start = 1'b0;
      check("ign_err", err, 1'b0);
      check("ign_busy", busy, 1'b1);
      send_bytes(4, 8, 0);
      wait_done(dcyc);
      verify_load("ign", sb, ab, dcyc);

      // Abort after two bytes of the second word
      sb = str_dat_q.size();
      do_start(16'd8);
      send_bytes(0, 6, 0);
      pulse_abort();
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_err", err, 1'b0);
      check("abort_ready", byte_ready, 1'b0);
      check("abort_hold_data", SelfWriteData, 32'h20a66cfb);
      repeat (10) @(posedge CLK);
      check("abort_strobes", str_dat_q.size() - sb, 1);
      check("abort_word", (str_dat_q.size() > sb) ? str_dat_q[sb] : 32'd0, 32'h20a66cfb);
      stim_q = '{8'hd7, 8'h8b, 8'h1b, 8'hba};
      sb = str_dat_q.size();
      ab = acc_cyc_q.size();
      do_start(16'd4);
      send_bytes(0, 4, 0);
      wait_done(dcyc);
      verify_load("restart", sb, ab, dcyc);
      check("restart_word", (str_dat_q.size() > sb) ? str_dat_q[sb] : 32'd0, 32'hd78b1bba);

      // Abort during SETUP: no strobe, the new word stays on SelfWriteData
      stim_q = '{8'h31, 8'h42, 8'h53, 8'h64};
      sb = str_dat_q.size();
      do_start(16'd4);
      send_bytes(0, 4, 0);
      pulse_abort();
      repeat (8) @(posedge CLK);
      check("abort_setup_strobes", str_dat_q.size() - sb, 0);
      check("abort_setup_data", SelfWriteData, 32'h31425364);
      check("abort_setup_busy", busy, 1'b0);

      // Randomized loads with random byte_valid gaps
      for (int r = 0; r < 4; r++) begin
         len = 4 * $urandom_range(1, 12);
         stim_q.delete();
         for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom_range(0, 255)));
         sb = str_dat_q.size();
         ab = acc_cyc_q.size();
         do_start(16'(len));
         send_bytes(0, len, 2);
         wait_done(dcyc);
         verify_load($sformatf("rand%0d", r), sb, ab, dcyc);
      end

      // Reset during STROBE, then start in the first cycle after release
      stim_q = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
      do_start(16'd4);
      send_bytes(0, 4, 0);
      n = 0;
      while (!SelfWriteStrobe && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("rst_mid_reached_strobe", SelfWriteStrobe, 1'b1);
      #2 resetn = 1'b0;
      #1;
      check("rst_mid_strobe", SelfWriteStrobe, 1'b0);
      check("rst_mid_data", SelfWriteData, 32'd0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_ready", byte_ready, 1'b0);
      check("rst_mid_done", done, 1'b0);
      check("rst_mid_err", err, 1'b0);
      repeat (2) @(posedge CLK);
      sb = str_dat_q.size();
      #1 resetn = 1'b1;
      stim_q = '{8'h01, 8'h23, 8'h45, 8'h67};
      ab = acc_cyc_q.size();
      start = 1'b1;
      total_bytes = 16'd4;
      @(posedge CLK); #1;
      start = 1'b0;
      check("post_rst_first_start", busy, 1'b1);
      send_bytes(0, 4, 0);
      wait_done(dcyc);
      verify_load("post_rst", sb, ab, dcyc);

      // Full-length load of incrementing bytes
      stim_q.delete();
      for (int i = 0; i < 21140; i++) stim_q.push_back(8'(i));
      sb = str_dat_q.size();
      ab = acc_cyc_q.size();
      do_start(16'd21140);
      send_bytes(0, 21140, 0);
      wait_done(dcyc);
      verify_load("full", sb, ab, dcyc);
      check("full_last_word",
            (str_dat_q.size() > 0) ? str_dat_q[str_dat_q.size()-1] : 32'd0, 32'h90919293);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bitstream_word_loader.md
BITSTREAM_WORD_LOADER -- requirements
Module: bitstream_word_loader

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 21140: largest accepted bitstream length in bytes.
REQ-002 SHALL have parameter SETUP_CYC, default 2: cycles SelfWriteData is stable before the strobe.
REQ-003 SHALL have parameter GAP_CYC, default 2: idle cycles after each strobe.
REQ-004 SHALL have port CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a load.
REQ-007 SHALL have port total_bytes  in  16  load length in bytes, sampled with start.
REQ-008 SHALL have port abort  in  1  synchronous cancel of the current load.
REQ-009 SHALL have port byte_data  in  8  incoming bitstream byte.
REQ-010 SHALL have port byte_valid  in  1  byte_data is valid.
REQ-011 SHALL have port byte_ready  out  1  loader accepts a byte this cycle.
REQ-012 SHALL have port SelfWriteData  out  32  packed configuration word to the fabric.
REQ-013 SHALL have port SelfWriteStrobe  out  1  one-cycle write pulse to the fabric.
REQ-014 SHALL have port busy  out  1  load in progress.
REQ-015 SHALL have port done  out  1  last load completed.
REQ-016 SHALL have port err  out  1  last start was rejected.

Function
REQ-017 SHALL implement the states IDLE, COLLECT, SETUP, STROBE, GAP and DONE.
REQ-018 SHALL accept a byte only in a cycle where byte_valid and byte_ready are both high; byte_ready SHALL be high only in COLLECT.
REQ-019 SHALL pack bytes MSB-first: the 1st byte of a word goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-020 SHALL act on start only in IDLE or DONE; start SHALL be ignored in every other state.
REQ-021 On start with total_bytes equal to 0, not a multiple of 4, or greater than MAX_BYTES: err=1, done=0, state goes to IDLE, no strobe is issued.
REQ-022 On a valid start: err=0, done=0, total_bytes latched, word and byte counters cleared, state goes to COLLECT.
REQ-023 If the 4th byte of a word is accepted in cycle C, then:
- SelfWriteData SHALL be updated at the end of C and held until the next word is loaded.
- The block SHALL be in SETUP for cycles C+1..C+SETUP_CYC.
- SelfWriteStrobe SHALL be 1 for exactly the one cycle C+SETUP_CYC+1 (STROBE).
- The block SHALL be in GAP for the next GAP_CYC cycles.
REQ-024 After GAP ends, the block SHALL go to DONE if the words written equal total_bytes/4, and to COLLECT otherwise.
REQ-025 In DONE: done=1 and busy=0, held until the next accepted start or reset.
REQ-026 busy SHALL be 1 in COLLECT, SETUP, STROBE and GAP, and 0 in IDLE and DONE.
REQ-027 Gaps in byte_valid SHALL only stall COLLECT; they SHALL never change the timing of SETUP, STROBE or GAP.
REQ-028 abort SHALL take priority over all other events; when high in a busy state:
- next state is IDLE, a partial word is discarded, done=0 and err=0;
- SelfWriteStrobe is 0 from the next cycle;
- SelfWriteData keeps its last value.
REQ-029 Counters SHALL be 16 bits; the byte counter SHALL not wrap because of the MAX_BYTES check.

Reset
REQ-030 resetn low SHALL asynchronously force state IDLE, SelfWriteData=0, SelfWriteStrobe=0, byte_ready=0, busy=0, done=0, err=0 and all counters to 0.
REQ-031 Reset asserted mid-strobe SHALL drop SelfWriteStrobe at once, with no extra pulse after release.
REQ-032 The first start SHALL be honoured in the first cycle after resetn rises.

Verification
REQ-033 Basic load: start with total_bytes=8, then bytes 20 a6 6c fb 0a 45 16 cf with byte_valid always high -> two strobes, data 0x20a66cfb then 0x0a4516cf; strobe at C+3 with default parameters; done=1 at C+6 after the 8th byte.
REQ-034 Backpressure: same stream with byte_valid low on alternate cycles -> identical words, strobe count 2, SETUP/STROBE/GAP spacing unchanged.
REQ-035 Reject: start with total_bytes=6, then with 21144 -> err=1, busy=0, zero strobes; a following start with total_bytes=4 clears err.
REQ-036 Abort: abort after 2 bytes of the second word (total_bytes=8) -> IDLE, exactly one strobe (0x20a66cfb), done=0; restart with total_bytes=4 and bytes d7 8b 1b ba -> one strobe with 0xd78b1bba.
REQ-037 Ignored start / reset: start pulsed in SETUP -> no effect; resetn pulsed low during STROBE -> strobe falls immediately, all outputs at reset values, no further strobes.
REQ-038 Full length: total_bytes=21140 of incrementing bytes -> exactly 5285 strobes, last word 0x90919293, done=1.
